scanline_buffer: RTL

Double-banked scanline buffer between the pixel source (rasteriser/blitter) and the VGA timing/decode stage. Upstream renders line N+1 into one bank over a valid/ready stream while the display stage reads line N from the other bank. The display stage indexes the buffer with its own `pixel`/`line` counters. The buffer returns one RGB332 byte per pixel, one clock later.

---
 rtl/scanline_pkg.sv | 26 ++
 rtl/scanline_ram.sv | 30 +++
 rtl/scanline_buffer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/scanline_pkg.sv
// Shared constants, fill FSM state type and line-sequencing helper for the
// double-banked scanline buffer.
package scanline_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_TOTAL_DEF  = 525;
  localparam int IDX_W        = 10;

  localparam logic [7:0] UNDERRUN_COLOUR = 8'hE3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // Line that follows cur, wrapping at the end of the frame (blanking included).
  function automatic logic [IDX_W-1:0] next_line(input logic [IDX_W-1:0] cur,
                                                 input logic [IDX_W-1:0] v_total);
    logic [IDX_W-1:0] inc;
    inc = cur + IDX_W'(1);
    return (inc == v_total) ? '0 : inc;
  endfunction

endpackage

// File: rtl/scanline_ram.sv
// Two-bank simple dual-port pixel store: one write port, one registered read
// port, addressed as {bank, index}. No reset so it maps onto block RAM.
module scanline_ram #(
  parameter int DEPTH = 640,
  parameter int W     = 8,
  parameter int IW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wbank,
  input  logic [IW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          rbank,
  input  logic [IW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2][DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wbank][waddr] <= wdata;
    end
    rdata_q <= mem[rbank][raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/scanline_buffer.sv
// Double-banked scanline buffer: upstream fills line N+1 into one bank while
// the display reads line N from the other. Optional SCANLINE_UNDERRUN_FILL_EN
// paints the unfilled tail of an aborted line with UNDERRUN_COLOUR.
//
// Write handshake: a beat transfers on a rising clk100 edge where wr_valid and
// wr_ready are both high; wr_ready depends only on the fill FSM state, never on
// wr_valid, and wr_data must be stable while wr_valid is high.
module scanline_buffer
  import scanline_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int PIXEL_W  = 8
) (
  input  logic               clk100,
  input  logic               rst_n,
  input  logic [9:0]         pixel,
  input  logic [9:0]         line,
  output logic [PIXEL_W-1:0] px_data,
  output logic               line_req,
  output logic [9:0]         req_line,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [PIXEL_W-1:0] wr_data,
  output logic               underrun,
  output logic [15:0]        underrun_cnt,
  output fill_state_t        fill_state
);

  localparam logic [9:0] H_ACTIVE_L = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST_L   = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_ACTIVE_L = 10'(V_ACTIVE);
  localparam logic [9:0] V_TOTAL_L  = 10'(V_TOTAL);

  fill_state_t state_q, state_d;
  logic [9:0]  prev_line_q, prev_line_d;
  logic [9:0]  wr_addr_q, wr_addr_d;
  logic        line_req_q, line_req_d;
  logic [9:0]  req_line_q, req_line_d;
  logic        underrun_q, underrun_d;
  logic [15:0] underrun_cnt_q, underrun_cnt_d;
  logic        rd_valid_q, rd_valid_d;

  logic        line_change;
  logic [9:0]  nxt_line;
  logic        issue;
  logic        beat;
  logic        last_beat;
  logic        abort;
  logic        wr_en;
  logic        rd_in_range;
  logic [9:0]  rd_addr;
  logic [PIXEL_W-1:0] ram_rdata;

  // Line sequencing and request / underrun decisions
  always_comb begin
    line_change = (line != prev_line_q);
    nxt_line    = next_line(line, V_TOTAL_L);
    issue       = line_change && (nxt_line < V_ACTIVE_L);
    beat        = wr_valid && wr_ready;
    last_beat   = beat && (wr_addr_q == H_LAST_L);
    // A fill whose final beat lands with the line change counts as complete.
    abort       = line_change && (state_q == FILL) && !last_beat;

    prev_line_d    = line;
    line_req_d     = issue;
    req_line_d     = issue ? nxt_line : req_line_q;
    underrun_d     = abort;
    underrun_cnt_d = underrun_cnt_q;
    if (abort && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end
  end

  // Fill FSM
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_ready  = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d   = FILL;
          wr_addr_d = '0;
        end
      end
      FILL: begin
        wr_ready = 1'b1;
        if (beat) begin
          wr_en     = 1'b1;
          wr_addr_d = wr_addr_q + 10'd1;
          if (last_beat) begin
            state_d = DONE;
          end
        end
        if (issue) begin
          state_d   = FILL;
          wr_addr_d = '0;
        end else if (abort) begin
          state_d   = IDLE;
          wr_addr_d = '0;
        end
      end
      DONE: begin
        if (issue) begin
          state_d   = FILL;
          wr_addr_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        wr_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      prev_line_q    <= '0;
      wr_addr_q      <= '0;
      line_req_q     <= 1'b0;
      req_line_q     <= '0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
      rd_valid_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_line_q    <= prev_line_d;
      wr_addr_q      <= wr_addr_d;
      line_req_q     <= line_req_d;
      req_line_q     <= req_line_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
      rd_valid_q     <= rd_valid_d;
    end
  end

  // Read side: out-of-range reads park the RAM address and force zero.
  always_comb begin
    rd_in_range = (line < V_ACTIVE_L) && (pixel < H_ACTIVE_L);
    rd_valid_d  = rd_in_range;
    rd_addr     = rd_in_range ? pixel : '0;
  end

  scanline_ram #(
    .DEPTH (H_ACTIVE),
    .W     (PIXEL_W),
    .IW    (10)
  ) u_ram (
    .clk   (clk100),
    .we    (wr_en),
    .wbank (req_line_q[0]),
    .waddr (wr_addr_q),
    .wdata (wr_data),
    .rbank (line[0]),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

`ifdef SCANLINE_UNDERRUN_FILL_EN
  logic [9:0] fill_level_q, fill_level_d;
  logic [9:0] ur_line_q, ur_line_d;
  logic       rd_fill_q, rd_fill_d;

  // fill_level marks where the aborted line stopped; cleared by any complete fill.
  always_comb begin
    fill_level_d = fill_level_q;
    ur_line_d    = ur_line_q;
    if (abort) begin
      fill_level_d = wr_addr_q;
      ur_line_d    = req_line_q;
    end else if (last_beat) begin
      fill_level_d = H_ACTIVE_L;
    end
    rd_fill_d = rd_in_range && (line == ur_line_q) && (pixel >= fill_level_q);
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      fill_level_q <= H_ACTIVE_L;
      ur_line_q    <= '0;
      rd_fill_q    <= 1'b0;
    end else begin
      fill_level_q <= fill_level_d;
      ur_line_q    <= ur_line_d;
      rd_fill_q    <= rd_fill_d;
    end
  end

  assign px_data = rd_fill_q  ? PIXEL_W'(UNDERRUN_COLOUR) :
                   rd_valid_q ? ram_rdata : '0;
`else
  assign px_data = rd_valid_q ? ram_rdata : '0;
`endif

  assign line_req     = line_req_q;
  assign req_line     = req_line_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
  assign fill_state   = state_q;

endmodule
